cdb_broadcaster: RTL and testbench
==================================

// Module: cdb_broadcaster
// PURPOSE
//  Transmit side of the common data bus (CDB). Collects completed results (tag, value) from
//  NUM_FU functional units, buffers them in a small FIFO per FU, and broadcasts up to NUM_CDB
//  results per cycle on the funcUnitTags/funcUnitOut/valueReady lanes. Reservation slots snoop
//  these lanes to capture operands. Sits between the FU outputs and every reservation station.
// PARAMETERS
//  NUM_FU      8   number of functional-unit result sources
//  NUM_CDB     2   number of broadcast lanes per cycle (1..NUM_FU)
//  BIT_WIDTH   32  result value width
//  TAG_WIDTH   8   producer tag width; tag 0 is reserved (means "no producer")
//  FIFO_DEPTH  2   entries per FU result FIFO (power of 2, >=2)
// PORTS
//  clk           in   1                     clock, all state on rising edge
//  reset         in   1                     asynchronous, active-low reset
//  fu_valid      in   NUM_FU                FU i presents a result
//  fu_ready      out  NUM_FU                FU i result FIFO can accept
//  fu_tag        in   TAG_WIDTH  x NUM_FU   result tag per FU
//  fu_value      in   BIT_WIDTH  x NUM_FU   result value per FU
//  funcUnitTags  out  TAG_WIDTH  x NUM_CDB  broadcast tag per lane
//  funcUnitOut   out  BIT_WIDTH  x NUM_CDB  broadcast value per lane
//  valueReady    out  NUM_CDB               lane k carries a valid result this cycle
// BEHAVIOUR
//  - Reset (async, reset==0): FIFOs emptied, rr_ptr=0, valueReady=0, funcUnitTags=0,
//    funcUnitOut=0; fu_ready forced 0 while reset asserted, 1 on first cycle after release.
//  - Accept: push into FIFO i at edge when fu_valid[i] && fu_ready[i]. fu_ready[i] = (count[i] <
//    FIFO_DEPTH), from current count only (same-cycle pop does NOT free a slot). FU must hold
//    tag/value stable while valid && !ready. fu_tag==0 with fu_valid is a protocol error.
//  - Arbitration (combinational, each cycle): scan FIFOs from rr_ptr upward, wrapping mod NUM_FU;
//    the k-th non-empty FIFO found is granted lane k, k<NUM_CDB. At most NUM_CDB grants.
//  - Broadcast: lane outputs are registers. At each edge, granted heads are loaded into lanes
//    (valueReady[k]=1) and popped; ungranted lanes load valueReady=0, tag=0, value=0. Lanes fill
//    from 0 upward contiguously. Each result is broadcast for exactly one cycle, exactly once.
//  - rr_ptr: if >=1 grant, rr_ptr <= (index of last granted FIFO + 1) mod NUM_FU; else holds.
//  - Ordering: results from one FU broadcast in acceptance order; no ordering across FUs.
//  - Latency (no bypass): accept at edge N -> visible on lane after edge N+1 (1 idle cycle min).
//  - Simultaneous push+pop same FIFO: both happen, count unchanged. Push to full: impossible.
//  - Throughput: NUM_CDB results/cycle sustained when >=NUM_CDB FIFOs non-empty.
//  - Starvation-free: any non-empty FIFO granted within ceil(NUM_FU/NUM_CDB) cycles.
// CONFIGURATION
//  CDB_BYPASS_EN defined: an FU whose FIFO is empty and has fu_valid is arbitration-eligible in
//    the same cycle, using the incoming tag/value as head; if granted, accepted and loaded into
//    the lane at edge N with no FIFO write (valueReady high right after edge N). If not granted,
//    it is pushed normally. fu_ready rule unchanged.
//  Not defined: incoming results always go through the FIFO; latency as above.
// TESTING
//  1 Reset mid-traffic: 3 FIFOs non-empty, pull reset low -> valueReady=0 immediately, after
//    release fu_ready=all 1, no stale result ever broadcast.
//  2 Single result: FU3 pushes tag 0x15 val 0xDEADBEEF at edge N -> lane0 tag 0x15, valueReady=01
//    after edge N+1 (N with CDB_BYPASS_EN), 0 the cycle after.
//  3 Contention: all 8 FUs push one result same edge, rr_ptr=0 -> lanes get FU0,1 then 2,3 then
//    4,5 then 6,7 over four cycles; rr_ptr ends 0.
//  4 Full/backpressure: FU5 valid every cycle, other FUs saturating -> fu_ready[5]=0 at count 2,
//    no lost/duplicated tag, per-FU order preserved (scoreboard).
//  5 Fairness: FU0 and FU1 continuously valid, NUM_CDB=1 -> grants alternate FU0,FU1,FU0,...
//  6 Random soak 10k cycles: every accepted tag broadcast exactly once, one lane, valueReady
//    contiguous from lane 0.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
//   Transmit side of the common data bus. Each functional unit deposits
//   completed (tag, value) results into its own small FIFO; every cycle a
//   round-robin arbiter picks up to NUM_CDB non-empty FIFOs and loads their
//   heads into registered broadcast lanes, filling lanes from 0 upward.
//
//   Optional feature macro: CDB_BYPASS_EN
//     When defined, an FU whose FIFO is empty may compete with its incoming
//     result in the same cycle; a granted bypass result goes straight to a
//     lane without touching the FIFO. When undefined, every result is
//     written to its FIFO first, which adds one idle cycle of latency.
// -----------------------------------------------------------------------------
module cdb_broadcaster #(
  parameter int NUM_FU     = 8,
  parameter int NUM_CDB    = 2,
  parameter int BIT_WIDTH  = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_FU-1:0]                   fu_valid,
  output logic [NUM_FU-1:0]                   fu_ready,
  input  logic [NUM_FU-1:0][TAG_WIDTH-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][BIT_WIDTH-1:0]    fu_value,
  output logic [NUM_CDB-1:0][TAG_WIDTH-1:0]   funcUnitTags,
  output logic [NUM_CDB-1:0][BIT_WIDTH-1:0]   funcUnitOut,
  output logic [NUM_CDB-1:0]                  valueReady
);

  localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LANE_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [BIT_WIDTH-1:0] value;
  } result_t;

  // Per-FU result storage and bookkeeping
  result_t                      mem [NUM_FU][FIFO_DEPTH];
  logic [NUM_FU-1:0][PTR_W-1:0] wr_ptr;
  logic [NUM_FU-1:0][PTR_W-1:0] rd_ptr;
  logic [NUM_FU-1:0][CNT_W-1:0] count;
  logic [FU_W-1:0]              rr_ptr;

  logic [NUM_FU-1:0] not_empty;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  result_t           head [NUM_FU];

  result_t            lane_nxt [NUM_CDB];
  logic [NUM_CDB-1:0] lane_vld_nxt;
  logic               any_grant;
  logic [FU_W-1:0]    last_idx;

  // Occupancy flags and acceptance handshake; ready ignores a same-cycle pop
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      not_empty[i] = (count[i] != '0);
      fu_ready[i]  = reset && (count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  // Candidate head per FU: FIFO head, or the incoming result when bypassing
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (not_empty[i]) begin
        head[i]     = mem[i][rd_ptr[i]];
        eligible[i] = 1'b1;
      end else begin
`ifdef CDB_BYPASS_EN
        head[i]     = '{tag: fu_tag[i], value: fu_value[i]};
        eligible[i] = fu_valid[i] && fu_ready[i];
`else
        head[i]     = '0;
        eligible[i] = 1'b0;
`endif
      end
    end
  end

  // Round-robin scan from rr_ptr: k-th eligible FU found drives lane k
  always_comb begin
    int n_grant;
    int idx;
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    n_grant      = 0;
    idx          = 0;
    grant        = '0;
    last_idx     = '0;
    lane_vld_nxt = '0;
    for (int k = 0; k < NUM_CDB; k++) lane_nxt[k] = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (eligible[FU_W'(idx)] && (n_grant < NUM_CDB)) begin
        grant[FU_W'(idx)]                 = 1'b1;
        lane_vld_nxt[LANE_W'(n_grant)]    = 1'b1;
        lane_nxt[LANE_W'(n_grant)]        = head[FU_W'(idx)];
        last_idx                          = FU_W'(idx);
        n_grant                           = n_grant + 1;
      end
    end
    any_grant = (n_grant != 0);
  end

  // Pop granted stored heads; a granted bypass result skips the FIFO write
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]  = grant[i] && not_empty[i];
      push[i] = fu_valid[i] && fu_ready[i] && !(grant[i] && !not_empty[i]);
    end
  end

  // FIFO pointers and counts; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Result storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by count, so stale entries are never read and the RAM stays reset-free.
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= '{tag: fu_tag[i], value: fu_value[i]};
    end
  end

  // Broadcast lane registers and round-robin pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valueReady   <= '0;
      funcUnitTags <= '0;
      funcUnitOut  <= '0;
      rr_ptr       <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        valueReady[k]   <= lane_vld_nxt[k];
        funcUnitTags[k] <= lane_nxt[k].tag;
        funcUnitOut[k]  <= lane_nxt[k].value;
      end
      if (any_grant) begin
        rr_ptr <= (last_idx == FU_W'(NUM_FU - 1)) ? '0 : last_idx + FU_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// tb_cdb_broadcaster
//   Scoreboard bench: the driver records each accepted result in exp_q; an
//   independent monitor matches every broadcast lane against it (known tag,
//   correct value, oldest of its FU, lanes contiguous, idle lanes zero).
//   Directed sections check reset, latency, contention order, pointer wrap,
//   backpressure and fairness (second instance with one lane).
// -----------------------------------------------------------------------------
module tb_cdb_broadcaster;

  localparam int NUM_FU  = 8;
  localparam int NUM_CDB = 2;
  localparam int TW      = 8;
  localparam int BW      = 32;
  localparam int FU_W    = 3;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [FU_W-1:0] fu;
    logic [TW-1:0]   tag;
    logic [BW-1:0]   value;
  } item_t;

  logic clk = 1'b0;
  logic reset;

  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0]           fu_ready;
  logic [NUM_FU-1:0][TW-1:0]   fu_tag;
  logic [NUM_FU-1:0][BW-1:0]   fu_value;
  logic [NUM_CDB-1:0][TW-1:0]  funcUnitTags;
  logic [NUM_CDB-1:0][BW-1:0]  funcUnitOut;
  logic [NUM_CDB-1:0]          valueReady;

  logic [NUM_FU-1:0]           f_valid;
  logic [NUM_FU-1:0]           f_ready;
  logic [NUM_FU-1:0][TW-1:0]   f_tag;
  logic [NUM_FU-1:0][BW-1:0]   f_value;
  logic [0:0][TW-1:0]          f_tags;
  logic [0:0][BW-1:0]          f_out;
  logic [0:0]                  f_vr;

  int n_checks = 0;
  int n_errors = 0;

  item_t             exp_q [$];
  item_t             pend_item [NUM_FU];
  logic [NUM_FU-1:0] pend;
  logic [TW-1:0]     next_tag;
  int                acc_cnt [NUM_FU];
  logic              saw_ready5_low;

  always #5 clk = ~clk;

  cdb_broadcaster #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .BIT_WIDTH(BW),
                    .TAG_WIDTH(TW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_value(fu_value),
    .funcUnitTags(funcUnitTags), .funcUnitOut(funcUnitOut), .valueReady(valueReady)
  );

  cdb_broadcaster #(.NUM_FU(NUM_FU), .NUM_CDB(1), .BIT_WIDTH(BW),
                    .TAG_WIDTH(TW), .FIFO_DEPTH(2)) dut_fair (
    .clk(clk), .reset(reset),
    .fu_valid(f_valid), .fu_ready(f_ready), .fu_tag(f_tag), .fu_value(f_value),
    .funcUnitTags(f_tags), .funcUnitOut(f_out), .valueReady(f_vr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one cycle of stimulus at the falling edge; results that will be
  // accepted at the next rising edge go into the scoreboard.
  task automatic step(input logic [NUM_FU-1:0] want);
    @(negedge clk);
    for (int i = 0; i < NUM_FU; i++) begin
      if (want[i] && !pend[i]) begin
        pend_item[i] = '{fu: FU_W'(i), tag: next_tag, value: $urandom};
        pend[i]      = 1'b1;
        next_tag     = (next_tag == 8'hFF) ? 8'h01 : next_tag + 8'h01;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      fu_valid[i] = pend[i];
      fu_tag[i]   = pend[i] ? pend_item[i].tag : '0;
      fu_value[i] = pend[i] ? pend_item[i].value : '0;
    end
    if (!fu_ready[5]) saw_ready5_low = 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      if (pend[i] && fu_ready[i]) begin
        exp_q.push_back(pend_item[i]);
        pend[i] = 1'b0;
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic load(input int fu, input logic [TW-1:0] tag, input logic [BW-1:0] value);
    pend_item[fu] = '{fu: FU_W'(fu), tag: tag, value: value};
    pend[fu]      = 1'b1;
  endtask

  // Scoreboard monitor on the main instance
  always @(negedge clk) begin : monitor
    logic gap;
    logic older;
    int   hit;
    gap = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (valueReady[k]) begin
        check($sformatf("lane%0d_contiguous", k), gap, 0);
        hit = -1;
        for (int e = 0; e < exp_q.size(); e++)
          if (hit < 0 && exp_q[e].tag == funcUnitTags[k]) hit = e;
        check($sformatf("lane%0d_tag_%0h_known", k, funcUnitTags[k]), hit >= 0, 1);
        if (hit >= 0) begin
          check($sformatf("lane%0d_value_tag_%0h", k, funcUnitTags[k]),
                funcUnitOut[k], exp_q[hit].value);
          older = 1'b0;
          for (int e = 0; e < hit; e++)
            if (exp_q[e].fu == exp_q[hit].fu) older = 1'b1;
          check($sformatf("lane%0d_fu_order_tag_%0h", k, funcUnitTags[k]), older, 0);
          exp_q.delete(hit);
        end
      end else begin
        gap = 1'b1;
        check($sformatf("lane%0d_idle_zero", k), {funcUnitTags[k], funcUnitOut[k]}, 0);
      end
    end
  end

  initial begin
    logic [TW-1:0] ct [NUM_FU];
    logic [TW-1:0] a0, a7;
    int            w, acc5_start;

    reset = 1'b1;
    fu_valid = '0; fu_tag = '0; fu_value = '0;
    f_valid = '0; f_tag = '0; f_value = '0;
    pend = '0; next_tag = 8'h01; saw_ready5_low = 1'b0;
    for (int i = 0; i < NUM_FU; i++) acc_cnt[i] = 0;

    // Power-on reset
    #1 reset = 1'b0;
    #2;
    check("reset_value_ready", valueReady, 0);
    check("reset_fu_ready_low", fu_ready, 0);
    check("reset_lane_tags", funcUnitTags, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("release_fu_ready_high", fu_ready, 8'hFF);

    // Fairness on the single-lane instance: FU0, FU1 continuously valid
    @(negedge clk);
    f_tag[0] = 8'h01; f_tag[1] = 8'h02;
    f_value[0] = 32'h1111_0000; f_value[1] = 32'h2222_0000;
    f_valid = 8'h03;
    w = 0;
    while (!f_vr[0] && w < 6) begin
      @(negedge clk);
      w++;
    end
    check("fair_first_grant_seen", f_vr, 1);
    for (int n = 0; n < 12; n++) begin
      check($sformatf("fair_vr_cycle%0d", n), f_vr, 1);
      check($sformatf("fair_tag_cycle%0d", n), f_tags[0], (n % 2 == 0) ? 8'h01 : 8'h02);
      @(negedge clk);
    end
    f_valid = '0;

    // Reset mid-traffic with three FIFOs non-empty
    step(8'h07);
    step(8'h07);
    @(negedge clk);
    fu_valid = '0;
    pend = '0;
    #2 reset = 1'b0;
    #1;
    check("midreset_value_ready", valueReady, 0);
    check("midreset_fu_ready_low", fu_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("midreset_release_ready", fu_ready, 8'hFF);
    repeat (4) step('0);

    // Contention: all eight FUs push at once, rr_ptr at 0
    step('1);
    for (int i = 0; i < NUM_FU; i++) ct[i] = pend_item[i].tag;
    for (int c = 0; c < LAT + 5; c++) begin
      step('0);
      if (c < LAT || c >= LAT + 4) begin
        check($sformatf("contend_idle_c%0d", c), valueReady, 0);
      end else begin
        check($sformatf("contend_vr_c%0d", c), valueReady, 2'b11);
        check($sformatf("contend_lane0_c%0d", c), funcUnitTags[0], ct[2*(c-LAT)]);
        check($sformatf("contend_lane1_c%0d", c), funcUnitTags[1], ct[2*(c-LAT)+1]);
      end
    end

    // rr_ptr wrapped back to 0: FU0 must win lane 0 over FU7
    step(8'h81);
    a0 = pend_item[0].tag;
    a7 = pend_item[7].tag;
    repeat (LAT + 1) step('0);
    check("rr_wrap_lane0_fu0", funcUnitTags[0], a0);
    check("rr_wrap_lane1_fu7", funcUnitTags[1], a7);
    step('0);

    // Single result from FU3
    load(3, 8'h15, 32'hDEAD_BEEF);
    step(8'h08);
    for (int c = 0; c < LAT + 2; c++) begin
      step('0);
      check($sformatf("single_vr_c%0d", c), valueReady, (c == LAT) ? 2'b01 : 2'b00);
      if (c == LAT) begin
        check("single_tag", funcUnitTags[0], 8'h15);
        check("single_value", funcUnitOut[0], 32'hDEAD_BEEF);
      end
    end

    // Backpressure: every FU saturating
    saw_ready5_low = 1'b0;
    acc5_start = acc_cnt[5];
    repeat (40) step('1);
    check("bp_fu5_ready_dropped", saw_ready5_low, 1);
    check("bp_fu5_not_starved", (acc_cnt[5] - acc5_start) >= 7, 1);
    repeat (20) step('0);
    check("bp_drained", exp_q.size(), 0);
    check("bp_no_pending", pend, 0);

    // Random soak
    repeat (10000) step(NUM_FU'($urandom));
    repeat (30) step('0);
    check("soak_drained", exp_q.size(), 0);
    check("soak_no_pending", pend, 0);
    check("soak_final_idle", valueReady, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
